// File: rtl/pixel_coord_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_coord_gen
//  Description : Converts a snapshot of the current view into one complex
//                coordinate per screen pixel, in row-major order.
//                On start, it latches the zoom spans and the negated pan
//                offsets. Two serial restoring dividers then derive the
//                per-pixel steps dx = x_zoom / WIDTH and dy = y_zoom / HEIGHT.
//                The block then streams (c_re, c_im, px_x, px_y) over a
//                valid/ready handshake.
//                Values are 69-bit two's complement with 12 integer bits and
//                56 fractional bits.
//
//  Ports
//    clock       in   system clock, rising edge
//    reset       in   asynchronous active-high reset
//    start       in   begin a frame (only honoured when idle)
//    x_zoom      in   horizontal span, unsigned magnitude
//    y_zoom      in   vertical span, unsigned magnitude
//    x_offset    in   horizontal pan offset (left edge = -x_offset)
//    y_offset    in   vertical pan offset   (top edge  = -y_offset)
//    out_valid   out  pixel outputs valid
//    out_ready   in   consumer accepts current pixel
//    c_re        out  real coordinate of (px_x, px_y)
//    c_im        out  imaginary coordinate of (px_x, px_y)
//    px_x        out  pixel column
//    px_y        out  pixel row
//    busy        out  high whenever not idle
//    frame_done  out  single-cycle pulse after the last pixel is accepted
//
//  Revision    : 1.0  initial release
// ============================================================================
module pixel_coord_gen #(
   parameter int WIDTH  = 160,
   parameter int HEIGHT = 120,
   parameter int XW     = 8,
   parameter int YW     = 7
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [68:0]   x_zoom,
   input  logic [68:0]   y_zoom,
   input  logic [68:0]   x_offset,
   input  logic [68:0]   y_offset,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [68:0]   c_re,
   output logic [68:0]   c_im,
   output logic [XW-1:0] px_x,
   output logic [YW-1:0] px_y,
   output logic          busy,
   output logic          frame_done
);

   localparam int DW = 69;
   // The remainder register is shared in width by both axes.
   // Each divisor fits in its own pixel-counter width, so the wider of the two
   // counter widths is enough.
   localparam int RW = (XW > YW) ? XW : YW;

   localparam logic [RW:0]   X_DIV     = (RW+1)'(WIDTH);
   localparam logic [RW:0]   Y_DIV     = (RW+1)'(HEIGHT);
   localparam logic [XW-1:0] X_LAST    = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST    = YW'(HEIGHT - 1);
   localparam logic [6:0]    DIV_STEPS = 7'd69;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_SCAN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   // The divider shift registers hold the dividend at first. After 69 steps
   // they hold the quotient, and they keep that value as the scan step.
   logic [DW-1:0]  xquo_q, xquo_d;
   logic [DW-1:0]  yquo_q, yquo_d;
   logic [RW-1:0]  xrem_q, xrem_d;
   logic [RW-1:0]  yrem_q, yrem_d;
   logic [6:0]     cnt_q, cnt_d;

   logic [DW-1:0]  xbase_q, xbase_d;
   logic [DW-1:0]  ybase_q, ybase_d;

   logic [DW-1:0]  c_re_q, c_re_d;
   logic [DW-1:0]  c_im_q, c_im_d;
   logic [XW-1:0]  px_x_q, px_x_d;
   logic [YW-1:0]  px_y_q, px_y_d;

   logic [RW+DW-1:0] w_xstep;
   logic [RW+DW-1:0] w_ystep;

   // One restoring-division step. It shifts the next dividend bit (MSB
   // first) into the partial remainder. It then subtracts the divisor when
   // that fits, and shifts the resulting quotient bit in at the LSB.
   function automatic logic [RW+DW-1:0] div_step(
      input logic [RW-1:0] rem,
      input logic [DW-1:0] quo,
      input logic [RW:0]   divisor
   );
      logic [RW:0]   trial;
      logic [RW-1:0] diff;
      trial = {rem, quo[DW-1]};
      diff  = RW'(trial - divisor);
      if (trial >= divisor) begin
         return {diff, quo[DW-2:0], 1'b1};
      end
      return {trial[RW-1:0], quo[DW-2:0], 1'b0};
   endfunction

   assign w_xstep = div_step(xrem_q, xquo_q, X_DIV);
   assign w_ystep = div_step(yrem_q, yquo_q, Y_DIV);

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      xquo_d  = xquo_q;
      yquo_d  = yquo_q;
      xrem_d  = xrem_q;
      yrem_d  = yrem_q;
      cnt_d   = cnt_q;
      xbase_d = xbase_q;
      ybase_d = ybase_q;
      c_re_d  = c_re_q;
      c_im_d  = c_im_q;
      px_x_d  = px_x_q;
      px_y_d  = px_y_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // Snapshot the view. Later input changes cannot disturb
               // this frame.
               xquo_d  = x_zoom;
               yquo_d  = y_zoom;
               xrem_d  = '0;
               yrem_d  = '0;
               cnt_d   = '0;
               xbase_d = -x_offset;
               ybase_d = -y_offset;
               state_d = S_DIV;
            end
         end

         S_DIV: begin
            if (cnt_q == DIV_STEPS) begin
               // Both quotients are complete. Present the first pixel.
               c_re_d  = xbase_q;
               c_im_d  = ybase_q;
               px_x_d  = '0;
               px_y_d  = '0;
               state_d = S_SCAN;
            end else begin
               {xrem_d, xquo_d} = w_xstep;
               {yrem_d, yquo_d} = w_ystep;
               cnt_d            = cnt_q + 7'd1;
            end
         end

         S_SCAN: begin
            if (out_ready) begin
               if (px_x_q == X_LAST) begin
                  if (px_y_q == Y_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     // Reload the row base instead of accumulating, so
                     // column n is always exactly x_base + n*dx.
                     px_x_d = '0;
                     c_re_d = xbase_q;
                     px_y_d = px_y_q + YW'(1);
                     c_im_d = c_im_q + yquo_q;
                  end
               end else begin
                  px_x_d = px_x_q + XW'(1);
                  c_re_d = c_re_q + xquo_q;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         xquo_q  <= '0;
         yquo_q  <= '0;
         xrem_q  <= '0;
         yrem_q  <= '0;
         cnt_q   <= '0;
         xbase_q <= '0;
         ybase_q <= '0;
         c_re_q  <= '0;
         c_im_q  <= '0;
         px_x_q  <= '0;
         px_y_q  <= '0;
      end else begin
         xquo_q  <= xquo_d;
         yquo_q  <= yquo_d;
         xrem_q  <= xrem_d;
         yrem_q  <= yrem_d;
         cnt_q   <= cnt_d;
         xbase_q <= xbase_d;
         ybase_q <= ybase_d;
         c_re_q  <= c_re_d;
         c_im_q  <= c_im_d;
         px_x_q  <= px_x_d;
         px_y_q  <= px_y_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // SCAN is entered together with the first pixel load. It is left only
   // through the final transfer, so valid is simply "in SCAN".
   assign out_valid  = (state_q == S_SCAN);
   assign busy       = (state_q != S_IDLE);
   assign frame_done = (state_q == S_DONE);
   assign c_re       = c_re_q;
   assign c_im       = c_im_q;
   assign px_x       = px_x_q;
   assign px_y       = px_y_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_coord_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_coord_gen
//  Description : Self-checking bench for pixel_coord_gen.
//                It drives a full-size instance (160x120) and a small
//                instance (4x2). Scans are compared against a reference model
//                that computes each pixel from its index.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pixel_coord_gen;

   typedef logic [68:0] fx_t;

   localparam int W   = 160;
   localparam int H   = 120;
   localparam int XW  = 8;
   localparam int YW  = 7;
   localparam int WS  = 4;
   localparam int HS  = 2;
   localparam int XWS = 3;
   localparam int YWS = 2;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // Full-size instance
   logic          start_b = 1'b0, out_ready_b = 1'b0;
   fx_t           x_zoom_b = '0, y_zoom_b = '0, x_offset_b = '0, y_offset_b = '0;
   logic          out_valid_b, busy_b, frame_done_b;
   fx_t           c_re_b, c_im_b;
   logic [XW-1:0] px_x_b;
   logic [YW-1:0] px_y_b;

   // Small instance
   logic           start_s = 1'b0, out_ready_s = 1'b0;
   fx_t            x_zoom_s = '0, y_zoom_s = '0, x_offset_s = '0, y_offset_s = '0;
   logic           out_valid_s, busy_s, frame_done_s;
   fx_t            c_re_s, c_im_s;
   logic [XWS-1:0] px_x_s;
   logic [YWS-1:0] px_y_s;

   pixel_coord_gen #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut_b (
      .clock(clock), .reset(reset), .start(start_b),
      .x_zoom(x_zoom_b), .y_zoom(y_zoom_b), .x_offset(x_offset_b), .y_offset(y_offset_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b),
      .c_re(c_re_b), .c_im(c_im_b), .px_x(px_x_b), .px_y(px_y_b),
      .busy(busy_b), .frame_done(frame_done_b));

   pixel_coord_gen #(.WIDTH(WS), .HEIGHT(HS), .XW(XWS), .YW(YWS)) dut_s (
      .clock(clock), .reset(reset), .start(start_s),
      .x_zoom(x_zoom_s), .y_zoom(y_zoom_s), .x_offset(x_offset_s), .y_offset(y_offset_s),
      .out_valid(out_valid_s), .out_ready(out_ready_s),
      .c_re(c_re_s), .c_im(c_im_s), .px_x(px_x_s), .px_y(px_y_s),
      .busy(busy_s), .frame_done(frame_done_s));

   int tests = 0;
   int fails = 0;
   int done_b = 0;
   int done_s = 0;

   always @(negedge clock) begin
      if (frame_done_b) done_b++;
      if (frame_done_s) done_s++;
   end

   task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Runs one frame on the full-size instance and checks every cycle against
   // the model: pixel k is (k mod W, k div W) at base + column*dx, row*dy.
   // When disturb is set, the inputs and start toggle after the start edge.
   task automatic run_frame(input fx_t xz, input fx_t yz, input fx_t xo, input fx_t yo,
                            input int ready_pct, input bit disturb);
      fx_t  xb, yb, dx, dy, ex_re, ex_im;
      int   k, lat, guard, d0, col, row;
      logic rdy;
      logic [255:0] got, exp;
      xb = -xo;
      yb = -yo;
      dx = xz / fx_t'(W);
      dy = yz / fx_t'(H);
      d0 = done_b;
      x_zoom_b = xz; y_zoom_b = yz; x_offset_b = xo; y_offset_b = yo;
      out_ready_b = 1'b0;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      check("busy_after_start", busy_b, 1);
      lat = 0;
      for (int n = 1; n <= 200; n++) begin
         if (disturb) begin
            start_b    = 1'($urandom);
            x_offset_b = x_offset_b ^ (fx_t'(1) << 50);
            x_zoom_b   = {5'($urandom), $urandom, $urandom};
         end
         out_ready_b = 1'($urandom);
         step();
         if (out_valid_b) begin
            lat = n;
            break;
         end
      end
      check("first_valid_latency", lat, 70);
      if (lat == 0) return;
      k = 0;
      guard = 0;
      while (k < W * H) begin
         col   = k % W;
         row   = k / W;
         ex_re = xb + fx_t'(col) * dx;
         ex_im = yb + fx_t'(row) * dy;
         got = {out_valid_b, frame_done_b, busy_b, px_x_b, px_y_b, c_re_b, c_im_b};
         exp = {3'b101, XW'(col), YW'(row), ex_re, ex_im};
         tests++;
         if (got !== exp) begin
            fails++;
            $display("FAIL pixel[%0d]: got v=%b d=%b b=%b x=%0d y=%0d re=%h im=%h expected x=%0d y=%0d re=%h im=%h",
                     k, out_valid_b, frame_done_b, busy_b, px_x_b, px_y_b, c_re_b, c_im_b,
                     col, row, ex_re, ex_im);
         end
         if (!out_valid_b) return;
         rdy = ($urandom_range(99) < ready_pct);
         out_ready_b = rdy;
         if (disturb) begin
            start_b    = 1'($urandom);
            x_offset_b = x_offset_b + (fx_t'(1) << 50);
            y_zoom_b   = {5'($urandom), $urandom, $urandom};
         end
         step();
         if (rdy) k++;
         guard++;
         if (guard > 3 * W * H) begin
            check("scan_cycle_budget", guard, 0);
            return;
         end
      end
      start_b = 1'b0;
      out_ready_b = 1'b0;
      check("done_state_vdb", {out_valid_b, frame_done_b, busy_b}, 3'b011);
      step();
      check("idle_after_done_vdb", {out_valid_b, frame_done_b, busy_b}, 3'b000);
      check("frame_done_pulses", done_b - d0, 1);
      step();
      check("no_retrigger_busy", busy_b, 0);
   endtask

   typedef struct {
      logic rdy;
      logic valid;
      logic done;
      logic busy;
      int   col;   // -1: coordinate fields not compared
      int   row;
   } vec_t;

   vec_t tbl[12];

   initial begin
      fx_t  XB_S, YB_S, DX_S, DY_S, ex_re, ex_im;
      logic any_valid;
      int   d0;

      // Reset state, checked while reset is still asserted.
      #1;
      check("rst_big_outputs",
            {out_valid_b, busy_b, frame_done_b, px_x_b, px_y_b, c_re_b, c_im_b}, 0);
      check("rst_small_outputs",
            {out_valid_s, busy_s, frame_done_s, px_x_s, px_y_s, c_re_s, c_im_s}, 0);
      step();
      step();
      reset = 1'b0;
      step();
      check("idle_busy_low", busy_b, 0);

      // Reset in the middle of the divide.
      x_zoom_b = fx_t'(1) << 58; y_zoom_b = fx_t'(1) << 58;
      x_offset_b = fx_t'(1) << 57; y_offset_b = fx_t'(1) << 57;
      start_b = 1'b1;
      step();
      start_b = 1'b0;
      repeat (29) step();
      check("busy_mid_div", busy_b, 1);
      #3 reset = 1'b1;
      #1;
      check("async_reset_outputs",
            {out_valid_b, busy_b, frame_done_b, px_x_b, px_y_b, c_re_b, c_im_b}, 0);
      step();
      reset = 1'b0;
      step();

      // Default view with a consumer that is always ready.
      run_frame(fx_t'(1) << 58, fx_t'(1) << 58, fx_t'(1) << 57, fx_t'(1) << 57, 100, 1'b0);

      // Random view (wrapping sums), random backpressure, inputs and start
      // toggling mid-frame.
      run_frame({5'($urandom), $urandom, $urandom}, {5'($urandom), $urandom, $urandom},
                {5'($urandom), $urandom, $urandom}, {5'($urandom), $urandom, $urandom},
                70, 1'b1);

      // Small frame: hand-derived constants.
      // dx = floor((2^56+3)/4) = 2^54 and dy = 2^57/2 = 2^56.
      // x_offset = -(2^68) negates back onto itself.
      DX_S = fx_t'(1) << 54;
      DY_S = fx_t'(1) << 56;
      XB_S = fx_t'(1) << 68;
      YB_S = -(fx_t'(1) << 56);
      tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1,  0, 0};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1, 0};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1, 0};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1,  2, 0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1,  3, 0};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1,  0, 1};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1,  1, 1};
      tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1,  1, 1};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1,  2, 1};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1,  3, 1};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, -1, 0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, -1, 0};

      d0 = done_s;
      x_zoom_s = (fx_t'(1) << 56) + fx_t'(3);
      y_zoom_s = fx_t'(1) << 57;
      x_offset_s = fx_t'(1) << 68;
      y_offset_s = fx_t'(1) << 56;
      start_s = 1'b1;
      step();
      start_s = 1'b0;
      x_offset_s = fx_t'(1) << 50;
      x_zoom_s = '0;
      check("small_busy_after_start", busy_s, 1);
      any_valid = 1'b0;
      repeat (69) begin
         step();
         any_valid = any_valid | out_valid_s;
      end
      check("small_no_early_valid", any_valid, 0);
      step();
      for (int i = 0; i < 12; i++) begin
         check($sformatf("small_vdb[%0d]", i),
               {out_valid_s, frame_done_s, busy_s}, {tbl[i].valid, tbl[i].done, tbl[i].busy});
         if (tbl[i].col >= 0) begin
            ex_re = XB_S + fx_t'(tbl[i].col) * DX_S;
            ex_im = YB_S + fx_t'(tbl[i].row) * DY_S;
            check($sformatf("small_pix[%0d]", i),
                  {px_x_s, px_y_s, c_re_s, c_im_s},
                  {XWS'(tbl[i].col), YWS'(tbl[i].row), ex_re, ex_im});
         end
         out_ready_s = tbl[i].rdy;
         step();
      end
      check("small_frame_done_pulses", done_s - d0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
